mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: REG_WIDTH, default 64, datapath width; REG_COUNT, default 32, register-file entries; M_Ctrl_bits, default 5, memory control width; WB_Ctrl_bits, default 5, writeback control width.
REQ-002 Ports, in order (AW = $clog2(REG_COUNT), NB = REG_WIDTH/8), SHALL be:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- WB_Ctrl_in  in  WB_Ctrl_bits  writeback control from EX/MEM
- M_Ctrl_in  in  M_Ctrl_bits  memory control from EX/MEM
- ALU_res_in  in  REG_WIDTH  ALU result / effective byte address
- rs2_data_in  in  REG_WIDTH  store data
- rd_addr_in  in  AW  destination register
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  REG_WIDTH  address, aligned down to NB bytes
- dmem_wdata  out  REG_WIDTH  lane-shifted store data
- dmem_wstrb  out  NB  byte-lane write enables
- dmem_ready  in  1  memory accepted/completed request
- dmem_rdata  in  REG_WIDTH  read data, valid when dmem_ready
- stall_out  out  1  hold upstream pipeline
- misalign_err  out  1  one-cycle misaligned-access flag
- WB_Ctrl_out  out  WB_Ctrl_bits  to MEM/WB
- ALU_res_out  out  REG_WIDTH  to MEM/WB
- mem_data_out  out  REG_WIDTH  extended load data
- rd_addr_out  out  AW  to MEM/WB

Function
REQ-003 M_Ctrl_in encoding SHALL be: bit0 read, bit1 write, bit2 unsigned load, bits4:3 size (00 byte, 01 half, 10 word, 11 double); read and write both set SHALL be treated as write.
REQ-004 Access SHALL be aligned iff offset = ALU_res_in[log2(NB)-1:0] is a multiple of the size in bytes; a size larger than NB SHALL be treated as misaligned.
REQ-005 FSM states SHALL be IDLE and BUSY only.
REQ-006 IDLE with no read/write: on the next edge the outputs SHALL register WB_Ctrl_in, ALU_res_in and rd_addr_in, with mem_data_out = 0 (1-cycle latency).
REQ-007 IDLE with an aligned access: stall_out SHALL be 1 combinationally; on the edge, state -> BUSY and the request fields SHALL be registered; WB_Ctrl_out SHALL become 0 (bubble).
REQ-008 In BUSY: dmem_req = 1, with dmem_we/addr/wdata/wstrb held constant until a cycle with dmem_ready = 1.
REQ-009 In BUSY: stall_out = !dmem_ready; WB_Ctrl_out SHALL remain 0 each cycle dmem_ready = 0.
REQ-010 On the BUSY edge with dmem_ready = 1: state -> IDLE and the outputs SHALL register the captured WB_Ctrl, ALU_res and rd_addr; for loads, mem_data_out = bytes [offset, offset+size) of dmem_rdata, sign-extended (bit2 = 0) or zero-extended (bit2 = 1); for stores, mem_data_out = 0.
REQ-011 Stores SHALL drive dmem_wdata = rs2_data_in low bytes shifted left by offset*8, and dmem_wstrb = (2^size_bytes - 1) << offset.
REQ-012 Loads SHALL drive dmem_we = 0 and dmem_wstrb = 0.
REQ-013 Misaligned access in IDLE: no request; stall_out = 0; on the edge misalign_err = 1 for exactly one cycle and WB_Ctrl_out = 0.
REQ-014 Minimum access latency SHALL be 2 cycles; total stall cycles = 1 + (cycles waited for dmem_ready).
REQ-015 dmem_ready SHALL be ignored in IDLE; upstream input changes while stall_out = 1 SHALL be ignored.
REQ-016 Back-to-back accesses: the IDLE cycle after completion SHALL accept the next access.

Reset
REQ-017 While rst = 1, asynchronously: state = IDLE; dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, misalign_err and all pipeline outputs = 0.
REQ-018 Reset asserted in BUSY SHALL abandon the access immediately, with no output update on release.
REQ-019 The first edge after rst release SHALL be treated as IDLE.

Verification
REQ-020 LB (M_Ctrl = 5'b00001), address 0x1003, dmem_rdata = 0x0000_0000_8000_0000, ready on first BUSY cycle -> dmem_addr = 0x1000, mem_data_out = 0xFFFF_FFFF_FFFF_FF80, stall for 1 cycle.
REQ-021 SH (M_Ctrl = 5'b01010), address 0x2006, rs2 = 0x1234 -> dmem_we = 1, dmem_addr = 0x2000, dmem_wstrb = 0xC0, dmem_wdata[63:48] = 0x1234, WB_Ctrl_out = WB_Ctrl_in after completion.
REQ-022 LWU (M_Ctrl = 5'b10101), address 0x1002 -> dmem_req stays 0, misalign_err = 1 for one cycle, WB_Ctrl_out = 0, stall_out = 0.
REQ-023 LD, dmem_ready delayed 3 BUSY cycles -> stall_out = 1 for 4 cycles, request fields stable throughout, data = dmem_rdata.
REQ-024 rst pulse on the second BUSY cycle -> dmem_req = 0 immediately; after release, a non-memory op appears on outputs 1 cycle later.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the integer pipeline.
// Turns EX/MEM control into a single aligned data-memory request, stalls the
// upstream pipeline until the memory answers, extracts and extends load data,
// and presents the result to MEM/WB. Misaligned accesses never reach memory;
// they raise a one-cycle misalign_err and insert a bubble instead.
module mem_access_unit #(
   parameter int REG_WIDTH    = 64,
   parameter int REG_COUNT    = 32,
   parameter int M_Ctrl_bits  = 5,
   parameter int WB_Ctrl_bits = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WB_Ctrl_bits-1:0]      WB_Ctrl_in,
   input  logic [M_Ctrl_bits-1:0]       M_Ctrl_in,
   input  logic [REG_WIDTH-1:0]         ALU_res_in,
   input  logic [REG_WIDTH-1:0]         rs2_data_in,
   input  logic [$clog2(REG_COUNT)-1:0] rd_addr_in,
   output logic                         dmem_req,
   output logic                         dmem_we,
   output logic [REG_WIDTH-1:0]         dmem_addr,
   output logic [REG_WIDTH-1:0]         dmem_wdata,
   output logic [REG_WIDTH/8-1:0]       dmem_wstrb,
   input  logic                         dmem_ready,
   input  logic [REG_WIDTH-1:0]         dmem_rdata,
   output logic                         stall_out,
   output logic                         misalign_err,
   output logic [WB_Ctrl_bits-1:0]      WB_Ctrl_out,
   output logic [REG_WIDTH-1:0]         ALU_res_out,
   output logic [REG_WIDTH-1:0]         mem_data_out,
   output logic [$clog2(REG_COUNT)-1:0] rd_addr_out
);

   localparam int AW = $clog2(REG_COUNT);
   localparam int NB = REG_WIDTH / 8;
   localparam int OW = (NB > 1) ? $clog2(NB) : 1;   // byte-offset width
   localparam int DW = $clog2(REG_WIDTH);           // bit-index width

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, next_state;

   // Decoded view of the incoming request (only meaningful in IDLE)
   logic          rd_req, wr_req, acc_req, aligned;
   logic [1:0]    size;
   logic [OW-1:0] off;
   int            sb;                 // access size in bytes

   // Store data / strobes computed from the incoming request
   logic [REG_WIDTH-1:0] st_mask_data;
   logic [REG_WIDTH-1:0] st_wdata;
   logic [NB-1:0]        st_wstrb;

   // Fields captured when the request is launched
   logic [WB_Ctrl_bits-1:0] cap_wb;
   logic [REG_WIDTH-1:0]    cap_alu;
   logic [AW-1:0]           cap_rd;
   logic [OW-1:0]           cap_off;
   logic [1:0]              cap_size;
   logic                    cap_uns;

   // Load extraction from the returned word
   logic [REG_WIDTH-1:0] ld_sh;
   logic [REG_WIDTH-1:0] ld_data;
   int                   ld_bits;
   logic                 ld_sgn;

   assign rd_req  = M_Ctrl_in[0];
   assign wr_req  = M_Ctrl_in[1];       // read+write together behaves as a write
   assign acc_req = rd_req | wr_req;
   assign size    = M_Ctrl_in[4:3];
   assign off     = ALU_res_in[OW-1:0];

   // Alignment: offset must be a multiple of the size; oversize is never aligned
   always_comb begin
      sb      = 1 << size;
      aligned = (sb <= NB) && ((int'(off) & (sb - 1)) == 0);
   end

   // Store lane placement: keep the low sb bytes of rs2, shift into the lanes
   always_comb begin
      st_mask_data = '0;
      st_wstrb     = '0;
      for (int i = 0; i < REG_WIDTH; i++)
         st_mask_data[i] = (i < sb * 8) ? rs2_data_in[i] : 1'b0;
      st_wdata = st_mask_data << (int'(off) * 8);
      for (int b = 0; b < NB; b++)
         st_wstrb[b] = (b >= int'(off)) && (b < int'(off) + sb);
   end

   // Load extraction: move the addressed bytes down, then sign/zero extend
   always_comb begin
      ld_data = '0;
      ld_sh   = dmem_rdata >> (int'(cap_off) * 8);
      ld_bits = 8 << cap_size;
      if (ld_bits > REG_WIDTH) ld_bits = REG_WIDTH;
      ld_sgn  = !cap_uns && ld_sh[DW'(ld_bits - 1)];
      for (int i = 0; i < REG_WIDTH; i++)
         ld_data[i] = (i < ld_bits) ? ld_sh[i] : ld_sgn;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state and stall: stall while an access is being launched or waited on
   always_comb begin
      next_state = state;
      stall_out  = 1'b0;
      case (state)
         IDLE: begin
            if (acc_req && aligned) begin
               next_state = BUSY;
               stall_out  = 1'b1;
            end
         end
         BUSY: begin
            stall_out = !dmem_ready;
            if (dmem_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Request, capture and MEM/WB output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_wstrb   <= '0;
         misalign_err <= 1'b0;
         WB_Ctrl_out  <= '0;
         ALU_res_out  <= '0;
         mem_data_out <= '0;
         rd_addr_out  <= '0;
         cap_wb       <= '0;
         cap_alu      <= '0;
         cap_rd       <= '0;
         cap_off      <= '0;
         cap_size     <= '0;
         cap_uns      <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!acc_req) begin
                  // Pass-through of a non-memory instruction
                  WB_Ctrl_out  <= WB_Ctrl_in;
                  ALU_res_out  <= ALU_res_in;
                  rd_addr_out  <= rd_addr_in;
                  mem_data_out <= '0;
               end else if (!aligned) begin
                  // Kill the instruction: no request, bubble downstream
                  misalign_err <= 1'b1;
                  WB_Ctrl_out  <= '0;
                  ALU_res_out  <= ALU_res_in;
                  rd_addr_out  <= rd_addr_in;
                  mem_data_out <= '0;
               end else begin
                  // Launch: register the request, bubble until it completes
                  dmem_req    <= 1'b1;
                  dmem_we     <= wr_req;
                  dmem_addr   <= {ALU_res_in[REG_WIDTH-1:OW], {OW{1'b0}}};
                  dmem_wdata  <= wr_req ? st_wdata : '0;
                  dmem_wstrb  <= wr_req ? st_wstrb : '0;
                  WB_Ctrl_out <= '0;
                  cap_wb      <= WB_Ctrl_in;
                  cap_alu     <= ALU_res_in;
                  cap_rd      <= rd_addr_in;
                  cap_off     <= off;
                  cap_size    <= size;
                  cap_uns     <= M_Ctrl_in[2];
               end
            end
            BUSY: begin
               if (dmem_ready) begin
                  dmem_req     <= 1'b0;
                  dmem_we      <= 1'b0;
                  dmem_wstrb   <= '0;
                  WB_Ctrl_out  <= cap_wb;
                  ALU_res_out  <= cap_alu;
                  rd_addr_out  <= cap_rd;
                  mem_data_out <= dmem_we ? '0 : ld_data;
               end else begin
                  WB_Ctrl_out <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
